// File: rtl/ntt_input_packer_if.sv
// Handshake and vector bus between the serial coefficient source, the input packer
// and the permutation stage that consumes its bursts.
interface ntt_input_packer_if #(
  parameter int DATA_WIDTH_PER_INPUT = 32,
  parameter int INPUT_PER_CYCLE      = 32
);
  logic                                            in_valid;
  logic                                            in_ready;
  logic [DATA_WIDTH_PER_INPUT-1:0]                 in_data;
  logic                                            in_last;
  logic                                            out_start;
  logic                                            out_valid;
  logic [DATA_WIDTH_PER_INPUT*INPUT_PER_CYCLE-1:0] out_data;
  logic                                            frame_err;

  modport master (
    output in_valid, in_data, in_last,
    input  in_ready, out_start, out_valid, out_data, frame_err
  );

  modport slave (
    input  in_valid, in_data, in_last,
    output in_ready, out_start, out_valid, out_data, frame_err
  );
endinterface

// File: rtl/ntt_input_packer.sv
// Serial-to-vector NTT frame packer with a two-bank ping-pong store.
// Optional in_last framing check enabled by defining PACKER_FRAME_CHECK_EN.
module ntt_input_packer #(
  parameter int DATA_WIDTH_PER_INPUT = 32,
  parameter int INPUT_PER_CYCLE      = 32,
  parameter int N                    = 1024
) (
  input  logic             clk,
  input  logic             rst,
  ntt_input_packer_if.slave bus
);
  localparam int W       = DATA_WIDTH_PER_INPUT;
  localparam int P       = INPUT_PER_CYCLE;
  localparam int VECTORS = N / P;
  localparam int LW      = (P > 1) ? $clog2(P) : 1;
  localparam int VW      = (VECTORS > 1) ? $clog2(VECTORS) : 1;
  localparam logic [LW-1:0] LANE_LAST = LW'(P - 1);
  localparam logic [VW-1:0] VEC_LAST  = VW'(VECTORS - 1);

  typedef enum logic [1:0] {
    BANK_EMPTY,
    BANK_FILLING,
    BANK_FULL,
    BANK_DRAINING
  } bank_state_e;

  typedef enum logic {
    RD_IDLE,
    RD_DRAIN
  } rd_state_e;

  bank_state_e [1:0] bank_q, bank_w, bank_d;
  rd_state_e         rd_state_q, rd_state_d;

  logic          wbank_q, wbank_d;
  logic          rbank_q, rbank_d;
  logic [LW-1:0] lane_q, lane_d;
  logic [VW-1:0] wvec_q, wvec_d;
  logic [VW-1:0] rvec_q, rvec_d;

  logic [W*P-1:0] stage_q, stage_d, wr_vec;
  logic           mem_we;
  logic [W*P-1:0] mem [2][VECTORS];

  logic           out_start_q, out_start_d;
  logic           out_valid_q, out_valid_d;
  logic [W*P-1:0] out_data_q, out_data_d;

  logic write_open;
  logic accept;
  logic last_word;

  assign write_open   = (bank_q[wbank_q] == BANK_EMPTY) || (bank_q[wbank_q] == BANK_FILLING);
  assign bus.in_ready = write_open & ~rst;
  assign accept       = bus.in_valid & bus.in_ready;
  assign last_word    = (lane_q == LANE_LAST) && (wvec_q == VEC_LAST);

  // Lanes 0..P-2 collect in a staging register; the completed vector is written
  // to the bank in one shot when the final lane arrives.
  always_comb begin
    bank_w  = bank_q;
    wbank_d = wbank_q;
    lane_d  = lane_q;
    wvec_d  = wvec_q;
    stage_d = stage_q;
    mem_we  = 1'b0;
    wr_vec  = stage_q;
    wr_vec[int'(lane_q)*W +: W] = bus.in_data;
    if (accept) begin
      stage_d = wr_vec;
      mem_we  = (lane_q == LANE_LAST);
      if (bank_q[wbank_q] == BANK_EMPTY) begin
        bank_w[wbank_q] = BANK_FILLING;
      end
      if (last_word) begin
        bank_w[wbank_q] = BANK_FULL;
        wbank_d         = ~wbank_q;
        lane_d          = '0;
        wvec_d          = '0;
      end else if (lane_q == LANE_LAST) begin
        lane_d = '0;
        wvec_d = wvec_q + 1'b1;
      end else begin
        lane_d = lane_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[wbank_q][wvec_q] <= wr_vec;
    end
  end

  always_ff @(posedge clk) begin
    stage_q <= stage_d;
  end

  // Read side only touches FULL/DRAINING banks, the write side only EMPTY/FILLING,
  // so applying read updates on top of write updates never overrides a write.
  always_comb begin
    bank_d      = bank_w;
    rd_state_d  = rd_state_q;
    rbank_d     = rbank_q;
    rvec_d      = rvec_q;
    out_start_d = 1'b0;
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;
    case (rd_state_q)
      RD_IDLE: begin
        if (bank_q[rbank_q] == BANK_FULL) begin
          bank_d[rbank_q] = BANK_DRAINING;
          rvec_d          = '0;
          rd_state_d      = RD_DRAIN;
        end
      end
      RD_DRAIN: begin
        out_valid_d = 1'b1;
        out_start_d = (rvec_q == '0);
        out_data_d  = mem[rbank_q][rvec_q];
        if (rvec_q == VEC_LAST) begin
          bank_d[rbank_q] = BANK_EMPTY;
          rbank_d         = ~rbank_q;
          rvec_d          = '0;
          if (bank_q[~rbank_q] == BANK_FULL) begin
            bank_d[~rbank_q] = BANK_DRAINING;
          end else begin
            rd_state_d = RD_IDLE;
          end
        end else begin
          rvec_d = rvec_q + 1'b1;
        end
      end
      default: rd_state_d = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bank_q[0]   <= BANK_EMPTY;
      bank_q[1]   <= BANK_EMPTY;
      rd_state_q  <= RD_IDLE;
      wbank_q     <= 1'b0;
      rbank_q     <= 1'b0;
      lane_q      <= '0;
      wvec_q      <= '0;
      rvec_q      <= '0;
      out_start_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      bank_q      <= bank_d;
      rd_state_q  <= rd_state_d;
      wbank_q     <= wbank_d;
      rbank_q     <= rbank_d;
      lane_q      <= lane_d;
      wvec_q      <= wvec_d;
      rvec_q      <= rvec_d;
      out_start_q <= out_start_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign bus.out_start = out_start_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;

`ifdef PACKER_FRAME_CHECK_EN
  logic frame_err_q, frame_err_d;

  always_comb begin
    frame_err_d = frame_err_q | (accept & (bus.in_last != last_word));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_err_q <= 1'b0;
    end else begin
      frame_err_q <= frame_err_d;
    end
  end

  assign bus.frame_err = frame_err_q;
`else
  logic unused_in_last;
  assign unused_in_last = bus.in_last;
  assign bus.frame_err  = 1'b0;
`endif

endmodule

// File: tb/tb_ntt_input_packer.sv
// Directed bench for ntt_input_packer: full frames, back-to-back, gaps, resets, framing.
module tb_ntt_input_packer;
  localparam int W   = 32;
  localparam int P   = 32;
  localparam int N   = 1024;
  localparam int VEC = N / P;

`ifdef PACKER_FRAME_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  typedef struct {
    int             cyc;
    logic           start;
    logic [W*P-1:0] data;
  } rec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  rec_t q[$];

  ntt_input_packer_if #(.DATA_WIDTH_PER_INPUT(W), .INPUT_PER_CYCLE(P)) bus ();

  ntt_input_packer #(
    .DATA_WIDTH_PER_INPUT(W),
    .INPUT_PER_CYCLE(P),
    .N(N)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.out_valid === 1'b1) q.push_back('{cyc, bus.out_start, bus.out_data});
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] lane_of(input logic [W*P-1:0] d, input int j);
    return d[j*W +: W];
  endfunction

  task automatic drive_frame(input logic [31:0] base, input bit gaps, input int abort_at,
                             input int last_at, input bit probe, output int acc, output int lows);
    bit probe_pend = 1'b0;
    acc  = 0;
    lows = 0;
    for (int k = 0; k < N; k++) begin
      bit accepted = 1'b0;
      int tries    = 0;
      if (k == abort_at) begin
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        return;
      end
      while (!accepted) begin
        @(negedge clk);
        if (probe_pend) begin
          check("frame_err_set", bus.frame_err, EXP_ERR);
          probe_pend = 1'b0;
        end
        if (gaps && $urandom_range(0, 1) == 0) begin
          bus.in_valid = 1'b0;
          bus.in_last  = 1'b0;
        end else begin
          bus.in_valid = 1'b1;
          bus.in_data  = base + k;
          bus.in_last  = (k == last_at);
        end
        if (bus.in_valid && bus.in_ready) begin
          accepted = 1'b1;
          acc      = cyc + 1;
          if (probe && k == last_at) probe_pend = 1'b1;
        end else if (bus.in_valid) begin
          lows++;
        end
        tries++;
        if (!accepted && tries > 200) begin
          check("ready_timeout", 64'(k), 64'(N));
          return;
        end
      end
    end
  endtask

  task automatic idle_bus();
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic wait_burst(input int target);
    for (int i = 0; i < 200 && q.size() < target; i++) @(negedge clk);
    if (q.size() < target) check("burst_timeout", 64'(q.size()), 64'(target));
  endtask

  task automatic verify_burst(input string tag, input int idx, input logic [31:0] base, input int exp_cyc);
    int bad_d = 0;
    int bad_s = 0;
    int bad_c = 0;
    if (q.size() < idx + VEC) begin
      check({tag, "_present"}, 64'(q.size()), 64'(idx + VEC));
      return;
    end
    check({tag, "_latency"}, 64'(q[idx].cyc), 64'(exp_cyc));
    for (int v = 0; v < VEC; v++) begin
      if (q[idx+v].start !== (v == 0)) bad_s++;
      if (q[idx+v].cyc != q[idx].cyc + v) bad_c++;
      for (int j = 0; j < P; j++) begin
        if (lane_of(q[idx+v].data, j) !== base + 32'(v*P + j)) bad_d++;
      end
    end
    check({tag, "_v0_l0"}, 64'(lane_of(q[idx].data, 0)), 64'(base));
    check({tag, "_v31_l31"}, 64'(lane_of(q[idx+VEC-1].data, P-1)), 64'(base + N - 1));
    check({tag, "_data_errs"}, 64'(bad_d), 64'd0);
    check({tag, "_start_errs"}, 64'(bad_s), 64'd0);
    check({tag, "_gap_errs"}, 64'(bad_c), 64'd0);
  endtask

  initial begin
    int idx, idx2, acc, acc_b, lows, lows_b, seen;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_last  = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_in_ready", bus.in_ready, 1'b0);
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_out_start", bus.out_start, 1'b0);
    check("rst_out_data_or", |bus.out_data, 1'b0);
    check("rst_frame_err", bus.frame_err, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", bus.in_ready, 1'b1);

    // Single gap-free frame
    idx = q.size();
    drive_frame(32'h0, 1'b0, -1, N-1, 1'b0, acc, lows);
    idle_bus();
    wait_burst(idx + VEC);
    verify_burst("f0", idx, 32'h0, acc + 2);
    repeat (5) @(negedge clk);
    check("f0_len", 64'(q.size() - idx), 64'(VEC));

    // Back-to-back frames
    idx = q.size();
    drive_frame(32'h0, 1'b0, -1, N-1, 1'b0, acc, lows);
    drive_frame(32'h1000, 1'b0, -1, N-1, 1'b0, acc_b, lows_b);
    idle_bus();
    check("b2b_ready_lows", 64'(lows + lows_b), 64'd0);
    wait_burst(idx + 2*VEC);
    verify_burst("b2b_a", idx, 32'h0, acc + 2);
    verify_burst("b2b_b", idx + VEC, 32'h1000, acc_b + 2);
    if (q.size() >= idx + 2*VEC)
      check("b2b_idle_gap", 64'(q[idx+VEC].cyc - q[idx+VEC-1].cyc - 1), 64'(N - VEC));

    // Random input gaps
    idx = q.size();
    drive_frame(32'h0, 1'b1, -1, N-1, 1'b0, acc, lows);
    idle_bus();
    wait_burst(idx + VEC);
    verify_burst("gaps", idx, 32'h0, acc + 2);

    // Reset at word 500 discards the partial frame
    repeat (5) @(negedge clk);
    idx = q.size();
    drive_frame(32'h0, 1'b0, 500, N-1, 1'b0, acc, lows);
    repeat (40) @(negedge clk);
    check("no_partial_burst", 64'(q.size() - idx), 64'd0);
    drive_frame(32'h0, 1'b0, -1, N-1, 1'b0, acc, lows);
    idle_bus();
    wait_burst(idx + VEC);
    verify_burst("after_abort", idx, 32'h0, acc + 2);
    repeat (5) @(negedge clk);
    check("after_abort_len", 64'(q.size() - idx), 64'(VEC));

    // Reset during burst vector 10
    idx = q.size();
    drive_frame(32'h3000, 1'b0, -1, N-1, 1'b0, acc, lows);
    idle_bus();
    seen = 0;
    for (int i = 0; i < 100 && seen < 11; i++) begin
      @(negedge clk);
      if (bus.out_valid) seen++;
    end
    check("burst_reach_v10", 64'(seen), 64'd11);
    check("v10_lane0", 64'(lane_of(bus.out_data, 0)), 64'(32'h3000 + 10*P));
    rst = 1'b1;
    @(negedge clk);
    check("rst_valid_drop", bus.out_valid, 1'b0);
    check("rst_start_drop", bus.out_start, 1'b0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("aborted_burst_len", 64'(q.size() - idx), 64'd11);
    idx2 = q.size();
    drive_frame(32'h4000, 1'b0, -1, N-1, 1'b0, acc, lows);
    idle_bus();
    wait_burst(idx2 + VEC);
    verify_burst("post_burst_rst", idx2, 32'h4000, acc + 2);
    repeat (5) @(negedge clk);
    check("post_burst_rst_len", 64'(q.size() - idx2), 64'(VEC));

    // Misplaced in_last on word 511
    check("frame_err_clear", bus.frame_err, 1'b0);
    idx = q.size();
    drive_frame(32'h5000, 1'b0, -1, 511, 1'b1, acc, lows);
    idle_bus();
    wait_burst(idx + VEC);
    verify_burst("ferr", idx, 32'h5000, acc + 2);
    repeat (5) @(negedge clk);
    check("ferr_len", 64'(q.size() - idx), 64'(VEC));
    check("frame_err_held", bus.frame_err, EXP_ERR);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
